uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares one uart_tx serializer between N_REQ byte-stream requesters.
- Grant is held for a whole packet, from the first byte through the byte flagged last; the serializer is then drained before re-arbitration.
- Optional stall timeout aborts a packet whose owner stops supplying bytes, so other requesters cannot be starved.
- Sits between the debug/console producers and the single uart_tx instance.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- STALL_MAX, 64, max consecutive idle cycles mid-packet before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  byte being offered is the last of its packet.
- req_ready  out  N_REQ  byte accepted this cycle when valid&&ready.
- tx_data  out  8  byte to uart_tx.
- tx_req  out  1  transmit request to uart_tx.
- tx_cts  in  1  uart_tx can accept; a byte transfers on any cycle with tx_req&&tx_cts.
- tx_idle  in  1  uart_tx line fully idle.
- gnt_idx  out  clog2(N_REQ)  current/last granted requester.
- busy  out  1  state != IDLE.
- abort  out  1  one-cycle pulse on stall timeout.

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything.
  - Reset values: state=IDLE, rr_ptr=0, gnt_idx=0, stall_cnt=0, abort=0.
  - Combinational outputs then evaluate to req_ready=0, tx_req=0, tx_data=0, busy=0.
- States: IDLE, SEND, DRAIN.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning upward from rr_ptr, wrapping modulo N_REQ.
  - Next cycle: gnt_idx=winner, state=SEND, stall_cnt=0.
  - No byte is accepted in IDLE; arbitration latency is 1 cycle.
- SEND (combinational outputs, zero-cycle path):
  - tx_data = req_data of gnt_idx.
  - tx_req = req_valid[gnt_idx].
  - req_ready[gnt_idx] = tx_cts; all other req_ready bits = 0.
  - Transfer = req_valid[gnt_idx] && tx_cts. On transfer, stall_cnt=0.
  - If the transferred byte has req_last[gnt_idx]=1: state=DRAIN, rr_ptr=(gnt_idx+1) mod N_REQ.
  - If req_valid[gnt_idx]=0: stall_cnt increments. A cycle with valid=1 and cts=0 is not a stall; stall_cnt holds.
  - When STALL_MAX!=0 and stall_cnt reaches STALL_MAX-1 on a stall cycle:
    - abort=1 on the next cycle, for one cycle.
    - state=DRAIN, rr_ptr=(gnt_idx+1) mod N_REQ.
    - No further bytes are taken from that requester.
- DRAIN:
  - tx_req=0, req_ready=0.
  - Stay until a cycle samples tx_idle=1, then go to IDLE.
  - Minimum DRAIN dwell is 1 cycle, even if tx_idle is already 1.
- gnt_idx holds its value in DRAIN and IDLE until the next grant.
- busy=1 in SEND and DRAIN.
- A requester that drops valid and later resumes within the timeout continues the same packet.
- Requests from non-granted requesters are ignored and keep waiting; no combinational path exists from their valid to tx_req.
- A single-byte packet (last on the first byte) is legal: the sequence is SEND for 1 cycle, then DRAIN.
- rst asserted mid-packet aborts silently: abort stays 0 and the partial packet is dropped.
  - uart_tx finishes any byte already accepted; the arbiter's DRAIN on the next packet covers this.
- stall_cnt width is clog2(STALL_MAX+1) and it saturates; it never wraps.

Test Plan:
- Single requester, N_REQ=2: req 0 sends 0x41,0x42,0x43 (last on 0x43), tx_cts always 1.
  - Grant in cycle 1; three consecutive transfers with tx_data=0x41,0x42,0x43.
  - DRAIN until tx_idle; rr_ptr=1.
- Contention: req 0 and req 1 both valid from reset, each with a 2-byte packet (0x10,0x11 / 0x20,0x21).
  - Order on tx_data: 0x10,0x11, DRAIN, 0x20,0x21.
  - req_ready[1]=0 throughout req 0's packet.
- Fairness: req 0 has back-to-back 1-byte packets, req 1 has one 1-byte packet.
  - Grants alternate 0,1,0; req 0 never gets two consecutive grants while req 1 is waiting.
- Backpressure: tx_cts toggles 1,0,0,1 while req 0 holds valid.
  - Transfers only on cts=1 cycles; tx_data stable while cts=0; abort stays 0.
- Stall timeout with STALL_MAX=4: req 0 sends 0x55 (not last), then drops valid.
  - abort pulses exactly once, 4 stall cycles after the transfer.
  - State goes DRAIN then IDLE; a pending req 1 is granted next.
- Reset mid-packet: assert rst for 1 cycle during SEND.
  - Next cycle: busy=0, tx_req=0, gnt_idx=0, abort=0, rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb - round-robin arbiter sharing one uart_tx serializer between
// N_REQ byte-stream requesters.
//
// A requester keeps the grant for a whole packet, from its first byte through
// the byte flagged last. After that the serializer is drained before the next
// arbitration round. An optional stall timeout aborts a packet whose owner
// stops supplying bytes, so other requesters cannot be starved.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   req_valid  per-requester byte valid
//   req_data   per-requester byte, requester i on bits [8i+7:8i]
//   req_last   offered byte is the last of its packet
//   req_ready  byte accepted this cycle when valid && ready
//   tx_data    byte to uart_tx
//   tx_req     transmit request to uart_tx
//   tx_cts     uart_tx can accept; a byte moves on tx_req && tx_cts
//   tx_idle    uart_tx line fully idle
//   gnt_idx    current or last granted requester
//   busy       arbiter is in SEND or DRAIN
//   abort      one-cycle pulse on stall timeout
module uart_tx_arb #(
  parameter int N_REQ     = 2,
  parameter int STALL_MAX = 64,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_req,
  input  logic                 tx_cts,
  input  logic                 tx_idle,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 busy,
  output logic                 abort
);

  localparam int CNT_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam bit TIMEOUT_EN = (STALL_MAX > 0);
  localparam logic [CNT_W-1:0] STALL_LIM =
    (STALL_MAX > 0) ? CNT_W'(STALL_MAX - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] rr_ptr_s;
  logic [IDX_W-1:0] gnt_idx_s;
  logic [IDX_W-1:0] winner_s;
  logic [IDX_W-1:0] gnt_next_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] stall_cnt_s;
  logic             abort_s;
  logic             any_valid_s;

  // Round-robin winner: scan offsets from high to low so the lowest offset
  // from rr_ptr (the first set bit going upward with wrap) is written last.
  always_comb begin
    int idx_v;
    idx_v       = 0;
    winner_s    = rr_ptr_r;
    any_valid_s = |req_valid;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_v    = (int'(rr_ptr_r) + i) % N_REQ;
      winner_s = req_valid[idx_v] ? IDX_W'(idx_v) : winner_s;
    end
  end

  // Pointer to the requester after the current owner, modulo N_REQ.
  always_comb begin
    gnt_next_s = (int'(gnt_idx) == N_REQ - 1) ? {IDX_W{1'b0}}
                                              : gnt_idx + IDX_W'(1);
  end

  // Next-state logic and the zero-cycle datapath from the owner to uart_tx.
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    gnt_idx_s   = gnt_idx;
    stall_cnt_s = stall_cnt_r;
    abort_s     = 1'b0;
    req_ready   = {N_REQ{1'b0}};
    tx_req      = 1'b0;
    tx_data     = 8'h00;
    busy        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          gnt_idx_s   = winner_s;
          stall_cnt_s = {CNT_W{1'b0}};
          state_s     = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        busy               = 1'b1;
        tx_data            = req_data[8*int'(gnt_idx) +: 8];
        tx_req             = req_valid[gnt_idx];
        req_ready[gnt_idx] = tx_cts;
        if (req_valid[gnt_idx]) begin
          // Valid with cts low is backpressure, not a stall: count holds.
          if (tx_cts) begin
            stall_cnt_s = {CNT_W{1'b0}};
            if (req_last[gnt_idx]) begin
              state_s  = ST_DRAIN;
              rr_ptr_s = gnt_next_s;
            end else begin
              state_s = ST_SEND;
            end
          end else begin
            stall_cnt_s = stall_cnt_r;
          end
        end else if (TIMEOUT_EN && (stall_cnt_r == STALL_LIM)) begin
          abort_s  = 1'b1;
          state_s  = ST_DRAIN;
          rr_ptr_s = gnt_next_s;
        end else if (stall_cnt_r != CNT_MAX) begin
          stall_cnt_s = stall_cnt_r + CNT_W'(1);
        end else begin
          stall_cnt_s = stall_cnt_r;
        end
      end
      ST_DRAIN: begin
        // Entered on the previous edge, so tx_idle is first sampled one
        // cycle later: the minimum dwell is one cycle.
        busy = 1'b1;
        if (tx_idle) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer, grant, stall counter and abort pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= {IDX_W{1'b0}};
      gnt_idx     <= {IDX_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      abort       <= 1'b0;
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      gnt_idx     <= gnt_idx_s;
      stall_cnt_r <= stall_cnt_s;
      abort       <= abort_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb (N_REQ=2, STALL_MAX=4). Each test pushes
// the bytes a requester offers into a source queue and the bytes expected on
// tx_data, tagged with the expected grant, into exp_q. A monitor pops exp_q
// on every tx_req && tx_cts cycle. Directed timing checks cover latency,
// DRAIN dwell, backpressure, stall abort and reset.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_cts;
  logic        tx_idle;
  logic [0:0]  gnt_idx;
  logic        busy;
  logic        abort;

  int n_cmp = 0;
  int n_err = 0;
  int abort_cnt = 0;

  logic [8:0] sq0[$];    // {last, data} offered by requester 0
  logic [8:0] sq1[$];    // {last, data} offered by requester 1
  logic [8:0] exp_q[$];  // {grant, data} expected on the serializer side

  uart_tx_arb #(.N_REQ(2), .STALL_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .tx_cts    (tx_cts),
    .tx_idle   (tx_idle),
    .gnt_idx   (gnt_idx),
    .busy      (busy),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_neg();
    tick();
    @(negedge clk);
  endtask

  // Source driver: retire a byte after a sampled handshake, present the next.
  initial begin
    logic [1:0] hs;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    req_last  = 2'b00;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready & {2{~rst}};
      @(posedge clk);
      #2;
      if (hs[0] && sq0.size() > 0) void'(sq0.pop_front());
      if (hs[1] && sq1.size() > 0) void'(sq1.pop_front());
      req_valid[0]   = (sq0.size() > 0);
      req_data[7:0]  = (sq0.size() > 0) ? sq0[0][7:0] : 8'h00;
      req_last[0]    = (sq0.size() > 0) ? sq0[0][8] : 1'b0;
      req_valid[1]   = (sq1.size() > 0);
      req_data[15:8] = (sq1.size() > 0) ? sq1[0][7:0] : 8'h00;
      req_last[1]    = (sq1.size() > 0) ? sq1[0][8] : 1'b0;
    end
  end

  // Monitor: every serializer transfer is compared against the scoreboard.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tx_req && tx_cts) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_xfer: got data %02h from gnt %0d, required no transfer", tx_data, gnt_idx);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_data", 32'(tx_data), 32'(e[7:0]));
          chk("xfer_gnt", 32'(gnt_idx), 32'(e[8]));
          chk("xfer_ready_onehot", 32'(req_ready), e[8] ? 32'd2 : 32'd1);
        end
      end
      if (abort) abort_cnt++;
    end
  end

  // Wait until every offered byte is consumed and the arbiter is idle.
  task automatic wait_done(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && sq0.size() == 0 && sq1.size() == 0 && !busy) return;
      tick();
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s_timeout: got %0d bytes still expected, required 0", nm, exp_q.size());
    exp_q.delete();
    sq0.delete();
    sq1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst     = 1'b0;
    tx_cts  = 1'b1;
    tx_idle = 1'b1;
    sq0.delete();
    sq1.delete();
    exp_q.delete();
  endtask

  // Overall time guard.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish within 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    tx_cts  = 1'b1;
    tx_idle = 1'b1;

    // Reset state.
    tick_neg();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_gnt", 32'(gnt_idx), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    do_reset();

    // Single requester, three bytes, DRAIN held by tx_idle=0.
    tx_idle = 1'b0;
    tick();
    sq0.push_back({1'b0, 8'h41}); sq0.push_back({1'b0, 8'h42}); sq0.push_back({1'b1, 8'h43});
    exp_q.push_back({1'b0, 8'h41}); exp_q.push_back({1'b0, 8'h42}); exp_q.push_back({1'b0, 8'h43});
    @(negedge clk);
    chk("t1_idle_tx_req", 32'(tx_req), 32'd0);
    chk("t1_idle_ready", 32'(req_ready), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    tick_neg();
    chk("t1_send_busy", 32'(busy), 32'd1);
    chk("t1_first_byte", 32'(tx_data), 32'h41);
    tick_neg();
    chk("t1_second_byte", 32'(tx_data), 32'h42);
    tick_neg();
    chk("t1_third_byte", 32'(tx_data), 32'h43);
    tick_neg();
    chk("t1_drain_busy", 32'(busy), 32'd1);
    chk("t1_drain_tx_req", 32'(tx_req), 32'd0);
    chk("t1_drain_ready", 32'(req_ready), 32'd0);
    tick_neg();
    chk("t1_drain_hold", 32'(busy), 32'd1);
    tick();
    tx_idle = 1'b1;
    @(negedge clk);
    chk("t1_drain_sample", 32'(busy), 32'd1);
    tick_neg();
    chk("t1_back_idle", 32'(busy), 32'd0);
    chk("t1_gnt_hold", 32'(gnt_idx), 32'd0);
    // rr_ptr is now 1: requester 1 must win a tie.
    tick();
    sq0.push_back({1'b1, 8'h50});
    sq1.push_back({1'b1, 8'h60});
    exp_q.push_back({1'b1, 8'h60}); exp_q.push_back({1'b0, 8'h50});
    wait_done("t1", 60);

    // Contention from reset: two 2-byte packets.
    do_reset();
    sq0.push_back({1'b0, 8'h10}); sq0.push_back({1'b1, 8'h11});
    sq1.push_back({1'b0, 8'h20}); sq1.push_back({1'b1, 8'h21});
    exp_q.push_back({1'b0, 8'h10}); exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h20}); exp_q.push_back({1'b1, 8'h21});
    wait_done("t2", 60);

    // Fairness: grants alternate 0,1,0.
    do_reset();
    sq0.push_back({1'b1, 8'h30}); sq0.push_back({1'b1, 8'h31});
    sq1.push_back({1'b1, 8'h40});
    exp_q.push_back({1'b0, 8'h30}); exp_q.push_back({1'b1, 8'h40}); exp_q.push_back({1'b0, 8'h31});
    wait_done("t3", 60);

    // Backpressure: cts 1,0,0,1.
    do_reset();
    tick();
    sq0.push_back({1'b0, 8'h70}); sq0.push_back({1'b0, 8'h71}); sq0.push_back({1'b1, 8'h72});
    exp_q.push_back({1'b0, 8'h70}); exp_q.push_back({1'b0, 8'h71}); exp_q.push_back({1'b0, 8'h72});
    tick_neg();
    chk("t4_cts1_data", 32'(tx_data), 32'h70);
    for (int k = 0; k < 2; k++) begin
      tick();
      tx_cts = 1'b0;
      @(negedge clk);
      chk("t4_cts0_tx_req", 32'(tx_req), 32'd1);
      chk("t4_cts0_data_stable", 32'(tx_data), 32'h71);
      chk("t4_cts0_ready", 32'(req_ready), 32'd0);
    end
    tick();
    tx_cts = 1'b1;
    wait_done("t4", 60);
    chk("t4_no_abort", 32'(abort_cnt), 32'd0);

    // Stall timeout with STALL_MAX=4; requester 1 waits.
    do_reset();
    tick();
    sq0.push_back({1'b0, 8'h55});
    sq1.push_back({1'b1, 8'h66});
    exp_q.push_back({1'b0, 8'h55}); exp_q.push_back({1'b1, 8'h66});
    tick_neg();
    chk("t5_xfer_cycle_data", 32'(tx_data), 32'h55);
    for (int k = 2; k <= 5; k++) begin
      tick_neg();
      chk("t5_stall_no_abort", 32'(abort), 32'd0);
      chk("t5_stall_no_tx_req", 32'(tx_req), 32'd0);
      chk("t5_stall_busy", 32'(busy), 32'd1);
    end
    tick_neg();
    chk("t5_abort_pulse", 32'(abort), 32'd1);
    chk("t5_abort_drain", 32'(busy), 32'd1);
    chk("t5_abort_tx_req", 32'(tx_req), 32'd0);
    tick_neg();
    chk("t5_abort_end", 32'(abort), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    tick_neg();
    chk("t5_next_gnt", 32'(gnt_idx), 32'd1);
    wait_done("t5", 60);
    chk("t5_abort_count", 32'(abort_cnt), 32'd1);

    // Reset mid-packet while requester 1 owns the grant.
    do_reset();
    sq0.push_back({1'b1, 8'h88});
    exp_q.push_back({1'b0, 8'h88});
    wait_done("t6a", 60);
    tick();
    sq1.push_back({1'b0, 8'h80}); sq1.push_back({1'b0, 8'h81}); sq1.push_back({1'b1, 8'h82});
    exp_q.push_back({1'b1, 8'h80});
    tick_neg();
    chk("t6_owner", 32'(gnt_idx), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sq1.delete();
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_tx_req", 32'(tx_req), 32'd0);
    chk("t6_gnt", 32'(gnt_idx), 32'd0);
    chk("t6_abort", 32'(abort), 32'd0);
    chk("t6_partial_dropped", 32'(exp_q.size()), 32'd0);
    // rr_ptr back to 0: requester 0 must win the tie.
    tick();
    sq0.push_back({1'b1, 8'h90});
    sq1.push_back({1'b1, 8'h91});
    exp_q.push_back({1'b0, 8'h90}); exp_q.push_back({1'b1, 8'h91});
    wait_done("t6", 60);
    chk("t6_abort_count", 32'(abort_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
